shift_seq_engine: RTL and testbench
===================================

// Module: shift_seq_engine
// PURPOSE
//  Parametrised sequential shift unit. Accepts an operand, a shift amount and
//  a mode; performs the shift STEP bit positions per cycle; returns the result
//  on a valid/ready output port. Supersedes ad-hoc one-shot <<, >>, <<<, >>>
//  expressions in the behavioural test benches. Sits between a command
//  source and a result consumer.
// PARAMETERS
//  WIDTH  9                    operand/result width (bits), >= 2
//  STEP   1                    max bit positions shifted per cycle, 1..WIDTH
//  SHW    $clog2(WIDTH+1)+1    width of shift-amount field
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      command valid
//  in_ready   out  1      command accepted when in_valid && in_ready
//  in_data    in   WIDTH  operand
//  in_amt     in   SHW    shift amount (unsigned)
//  in_mode    in   3      000 SLL, 001 SRL, 010 SLA, 011 SRA, 100 ROL, 101 ROR
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer ready
//  out_data   out  WIDTH  result
//  out_zero   out  1      out_data == 0
//  out_err    out  1      mode was illegal; out_data = in_data unchanged
//  busy       out  1      FSM not in IDLE
// BEHAVIOUR
//  - rst_n sampled on clk: FSM->IDLE; in_ready=1; out_valid=0; out_data=0;
//    out_zero=0; out_err=0; busy=0. Reset mid-operation discards the work.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE. No overlap: in_ready=1 only in IDLE.
//  - IDLE: on accept, latch data, mode, rem=amt (clamped). rem==0 or illegal
//    mode -> DONE next cycle; else -> SHIFT.
//  - SHIFT: each cycle shift by s=min(STEP,rem); rem-=s; rem reaches 0 -> DONE.
//  - DONE: out_valid=1; out_data/out_zero/out_err stable while out_valid &&
//    !out_ready. On out_ready -> IDLE (in_ready=1 the following cycle).
//  - Latency accept->out_valid: 1 + ceil(rem/STEP) cycles (1 when rem==0).
//  - Clamp: shifts with amt >= WIDTH use rem=WIDTH. SLL/SRL/SLA -> 0.
//    SRA -> all bits = sign. Rotates use rem = amt mod WIDTH.
//  - SLA is identical to SLL. SRA fills with latched MSB each step.
//  - Modes 110/111 are always illegal: out_err=1.
//  - out_valid and in_ready are never high in the same cycle.
// CONFIGURATION
//  SHIFT_SEQ_ROTATE_EN defined:
//    ROL/ROR (100/101) are legal and rotate by rem, STEP bits per cycle.
//  SHIFT_SEQ_ROTATE_EN undefined:
//    100/101 are illegal, as are 11x: 1-cycle DONE, out_err=1,
//    out_data=in_data.
// STRUCTURE
//  - Package shift_seq_pkg:
//    - mode_t enum for the 3-bit modes.
//    - state_t enum {IDLE, SHIFT, DONE}.
//    - function is_legal(mode_t) honouring SHIFT_SEQ_ROTATE_EN.
//  - Sub-module shift_seq_step: combinational single-step shifter
//    (data, s, mode -> data'). The engine instantiates one copy.
// TESTING
//  1 WIDTH=9,STEP=1: data=9'h0F3, amt=3, SLL -> out_data=9'h198 at 4th cycle
//    after accept; busy=1 throughout.
//  2 SRA data=9'h100 amt=4 -> 9'h1F0; SRA amt=12 (clamp) -> 9'h1FF; SRL amt=12
//    -> 9'h000, out_zero=1.
//  3 STEP=4: SRL data=9'h1FF amt=9 -> 9'h000 after 1+3 cycles; amt=0 -> data
//    unchanged after 1 cycle.
//  4 Backpressure: hold out_ready=0 for 5 cycles -> out_valid,out_data stable,
//    in_ready=0; release -> in_ready=1 next cycle, next command accepted.
//  5 Reset: assert rst_n=0 mid-SHIFT -> next cycle out_valid=0, busy=0,
//    in_ready=1, out_data=0.
//  6 mode=100, data=9'h101, amt=1: with SHIFT_SEQ_ROTATE_EN -> 9'h003;
//    without it -> out_err=1, out_data=9'h101.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - mode/state types and mode legality for the sequential shifter
// Optional feature: SHIFT_SEQ_ROTATE_EN enables ROL/ROR.
package shift_seq_pkg;

    typedef enum logic [2:0] {
        MODE_SLL  = 3'b000,
        MODE_SRL  = 3'b001,
        MODE_SLA  = 3'b010,
        MODE_SRA  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_RSV6 = 3'b110,
        MODE_RSV7 = 3'b111
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    function automatic logic is_legal(input mode_t m);
        logic legal;
        case (m)
            MODE_SLL, MODE_SRL, MODE_SLA, MODE_SRA: legal = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
            MODE_ROL, MODE_ROR:                     legal = 1'b1;
`endif
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/shift_seq_step.sv
// rtl/shift_seq_step.sv - combinational single-step shifter (s <= WIDTH positions)
// Rotate cases present only with SHIFT_SEQ_ROTATE_EN.
module shift_seq_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int SHW   = 5
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   s,
    input  mode_t            mode,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        case (mode)
            MODE_SLL, MODE_SLA: result = data << s;
            MODE_SRL:           result = data >> s;
            MODE_SRA:           result = $unsigned($signed(data) >>> s);
`ifdef SHIFT_SEQ_ROTATE_EN
            // s == 0 makes the wrap term shift by WIDTH, which yields zero
            MODE_ROL:           result = (data << s) | (data >> (SHW'(WIDTH) - s));
            MODE_ROR:           result = (data >> s) | (data << (SHW'(WIDTH) - s));
`endif
            default:            result = data;
        endcase
    end

endmodule

// File: rtl/shift_seq_engine.sv
// rtl/shift_seq_engine.sv - multi-cycle shift engine, STEP bits per cycle, valid/ready ports
// Optional feature: SHIFT_SEQ_ROTATE_EN enables ROL/ROR modes.
module shift_seq_engine
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int STEP  = 1,
    parameter int SHW   = $clog2(WIDTH + 1) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_err,
    output logic             busy
);

    localparam logic [SHW-1:0] WIDTH_SH = SHW'(WIDTH);
    localparam logic [SHW-1:0] STEP_SH  = SHW'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    mode_t            mode_q;
    logic [SHW-1:0]   rem_q;
    logic             err_q;

    mode_t            mode_in;
    logic [SHW-1:0]   rem_init;
    logic [SHW-1:0]   s;
    logic [WIDTH-1:0] step_out;
    logic             accept;

    assign mode_in = mode_t'(in_mode);
    assign accept  = in_valid && (state_q == IDLE);
    assign s       = (rem_q > STEP_SH) ? STEP_SH : rem_q;

    // Rotates wrap the amount; plain shifts saturate at WIDTH, which already
    // produces all-zero or all-sign results after the full walk.
    always_comb begin
        rem_init = in_amt;
        if (mode_in == MODE_ROL || mode_in == MODE_ROR)
            rem_init = in_amt % WIDTH_SH;
        else if (in_amt >= WIDTH_SH)
            rem_init = WIDTH_SH;
    end

    shift_seq_step #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_step (
        .data   (data_q),
        .s      (s),
        .mode   (mode_q),
        .result (step_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = (!is_legal(mode_in) || rem_init == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (rem_q <= STEP_SH)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            mode_q <= MODE_SLL;
            rem_q  <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            data_q <= in_data;
            mode_q <= mode_in;
            rem_q  <= rem_init;
            err_q  <= !is_legal(mode_in);
        end else if (state_q == SHIFT) begin
            data_q <= step_out;
            rem_q  <= rem_q - s;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;
    assign out_zero  = out_valid && (data_q == '0);
    assign out_err   = out_valid && err_q;

endmodule

// File: tb/tb_shift_seq_engine.sv
// tb/tb_shift_seq_engine.sv - directed self-checking bench for shift_seq_engine (STEP=1 and STEP=4)
module tb_shift_seq_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [8:0] a_in_data = '0, a_out_data;
    logic [4:0] a_in_amt = '0;
    logic [2:0] a_in_mode = '0;
    logic       a_out_zero, a_out_err, a_busy;

    logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [8:0] b_in_data = '0, b_out_data;
    logic [4:0] b_in_amt = '0;
    logic [2:0] b_in_mode = '0;
    logic       b_out_zero, b_out_err, b_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_seq_engine #(.WIDTH(9), .STEP(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_amt(a_in_amt), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_zero(a_out_zero), .out_err(a_out_err), .busy(a_busy)
    );

    shift_seq_engine #(.WIDTH(9), .STEP(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_amt(b_in_amt), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_zero(b_out_zero), .out_err(b_out_err), .busy(b_busy)
    );

    task automatic run_cmd(input bit sel_b, input logic [8:0] d, input logic [4:0] amt,
                           input logic [2:0] m, output int lat, output logic [8:0] rd,
                           output logic rz, output logic re, output bit busy_ok);
        @(negedge clk);
        if (sel_b) begin b_in_valid = 1; b_in_data = d; b_in_amt = amt; b_in_mode = m; end
        else       begin a_in_valid = 1; a_in_data = d; a_in_amt = amt; a_in_mode = m; end
        @(posedge clk); #1;
        a_in_valid = 0;
        b_in_valid = 0;
        lat = 1;
        busy_ok = 1;
        while (!(sel_b ? b_out_valid : a_out_valid) && lat < 64) begin
            if (!(sel_b ? b_busy : a_busy)) busy_ok = 0;
            @(posedge clk); #1;
            lat++;
        end
        if (!(sel_b ? b_busy : a_busy)) busy_ok = 0;
        rd = sel_b ? b_out_data : a_out_data;
        rz = sel_b ? b_out_zero : a_out_zero;
        re = sel_b ? b_out_err  : a_out_err;
    endtask

    task automatic release_out(input bit sel_b);
        @(negedge clk);
        if (sel_b) b_out_ready = 1; else a_out_ready = 1;
        @(posedge clk); #1;
        a_out_ready = 0;
        b_out_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
        n_cmp++; if (a_out_data !== 9'h000) begin n_bad++; $display("FAIL reset_out_data got %h want 000", a_out_data); end
        n_cmp++; if (a_out_zero !== 1'b0) begin n_bad++; $display("FAIL reset_out_zero got %b want 0", a_out_zero); end
        n_cmp++; if (a_out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got %b want 0", a_out_err); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", a_busy); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_sll();
        int lat; logic [8:0] rd; logic rz, re; bit bz;
        run_cmd(0, 9'h0F3, 5'd3, 3'b000, lat, rd, rz, re, bz);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL sll_latency got %0d want 4", lat); end
        n_cmp++; if (rd !== 9'h198) begin n_bad++; $display("FAIL sll_data got %h want 198", rd); end
        n_cmp++; if (bz !== 1'b1) begin n_bad++; $display("FAIL sll_busy got %b want 1", bz); end
        n_cmp++; if (rz !== 1'b0 || re !== 1'b0) begin n_bad++; $display("FAIL sll_flags got z=%b e=%b want 0 0", rz, re); end
        release_out(0);
    endtask

    task automatic test_sra_clamp();
        int lat; logic [8:0] rd; logic rz, re; bit bz;
        run_cmd(0, 9'h100, 5'd4, 3'b011, lat, rd, rz, re, bz);
        n_cmp++; if (rd !== 9'h1F0) begin n_bad++; $display("FAIL sra4_data got %h want 1F0", rd); end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL sra4_latency got %0d want 5", lat); end
        release_out(0);
        run_cmd(0, 9'h100, 5'd12, 3'b011, lat, rd, rz, re, bz);
        n_cmp++; if (rd !== 9'h1FF) begin n_bad++; $display("FAIL sra12_data got %h want 1FF", rd); end
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL sra12_latency got %0d want 10", lat); end
        release_out(0);
        run_cmd(0, 9'h1FF, 5'd12, 3'b001, lat, rd, rz, re, bz);
        n_cmp++; if (rd !== 9'h000) begin n_bad++; $display("FAIL srl12_data got %h want 000", rd); end
        n_cmp++; if (rz !== 1'b1) begin n_bad++; $display("FAIL srl12_zero got %b want 1", rz); end
        release_out(0);
    endtask

    task automatic test_step4();
        int lat; logic [8:0] rd; logic rz, re; bit bz;
        run_cmd(1, 9'h1FF, 5'd9, 3'b001, lat, rd, rz, re, bz);
        n_cmp++; if (rd !== 9'h000) begin n_bad++; $display("FAIL step4_srl9_data got %h want 000", rd); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL step4_srl9_latency got %0d want 4", lat); end
        release_out(1);
        run_cmd(1, 9'h0A5, 5'd0, 3'b001, lat, rd, rz, re, bz);
        n_cmp++; if (rd !== 9'h0A5) begin n_bad++; $display("FAIL step4_amt0_data got %h want 0A5", rd); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL step4_amt0_latency got %0d want 1", lat); end
        release_out(1);
        run_cmd(1, 9'h0F3, 5'd6, 3'b010, lat, rd, rz, re, bz);
        n_cmp++; if (rd !== 9'h0C0) begin n_bad++; $display("FAIL step4_sla6_data got %h want 0C0", rd); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL step4_sla6_latency got %0d want 3", lat); end
        release_out(1);
    endtask

    task automatic test_back_to_back();
        int lat; logic [8:0] rd; logic rz, re; bit bz;
        run_cmd(0, 9'h1F0, 5'd2, 3'b001, lat, rd, rz, re, bz);
        n_cmp++; if (rd !== 9'h07C) begin n_bad++; $display("FAIL bp_data got %h want 07C", rd); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, a_out_valid); end
            n_cmp++; if (a_out_data !== 9'h07C) begin n_bad++; $display("FAIL bp_hold_data[%0d] got %h want 07C", i, a_out_data); end
            n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_in_ready[%0d] got %b want 0", i, a_in_ready); end
        end
        release_out(0);
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready got %b want 1", a_in_ready); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid got %b want 0", a_out_valid); end
        run_cmd(0, 9'h003, 5'd2, 3'b010, lat, rd, rz, re, bz);
        n_cmp++; if (rd !== 9'h00C) begin n_bad++; $display("FAIL b2b_data got %h want 00C", rd); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL b2b_latency got %0d want 3", lat); end
        release_out(0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_in_valid = 1; a_in_data = 9'h0F3; a_in_amt = 5'd8; a_in_mode = 3'b000;
        @(posedge clk); #1;
        a_in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got %b want 1", a_busy); end
        @(negedge clk);
        rst_n = 0;
        @(posedge clk); #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out_valid got %b want 0", a_out_valid); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", a_busy); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_ready got %b want 1", a_in_ready); end
        n_cmp++; if (a_out_data !== 9'h000) begin n_bad++; $display("FAIL mid_rst_out_data got %h want 000", a_out_data); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_mode_rol_illegal();
        int lat; logic [8:0] rd; logic rz, re; bit bz;
        run_cmd(0, 9'h101, 5'd1, 3'b100, lat, rd, rz, re, bz);
`ifdef SHIFT_SEQ_ROTATE_EN
        n_cmp++; if (rd !== 9'h003) begin n_bad++; $display("FAIL rol_data got %h want 003", rd); end
        n_cmp++; if (re !== 1'b0) begin n_bad++; $display("FAIL rol_err got %b want 0", re); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rol_latency got %0d want 2", lat); end
`else
        n_cmp++; if (rd !== 9'h101) begin n_bad++; $display("FAIL rol_off_data got %h want 101", rd); end
        n_cmp++; if (re !== 1'b1) begin n_bad++; $display("FAIL rol_off_err got %b want 1", re); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rol_off_latency got %0d want 1", lat); end
`endif
        release_out(0);
        run_cmd(0, 9'h055, 5'd3, 3'b110, lat, rd, rz, re, bz);
        n_cmp++; if (rd !== 9'h055) begin n_bad++; $display("FAIL ill6_data got %h want 055", rd); end
        n_cmp++; if (re !== 1'b1) begin n_bad++; $display("FAIL ill6_err got %b want 1", re); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ill6_latency got %0d want 1", lat); end
        release_out(0);
        n_cmp++; if (a_out_err !== 1'b0) begin n_bad++; $display("FAIL ill6_err_after got %b want 0", a_out_err); end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_clamp();
        test_step4();
        test_back_to_back();
        test_reset_mid();
        test_mode_rol_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
